// File: rtl/keccak_pad_stream_if.sv
// rtl/keccak_pad_stream_if.sv - message word in / padded rate block out handshake bundle
interface keccak_pad_stream_if #(
    parameter int DIN_WIDTH = 64,
    parameter int RATE      = 1088
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DIN_WIDTH-1:0]          in_data;
    logic                          in_last;
    logic [$clog2(DIN_WIDTH/8):0]  in_bytes;
    logic                          out_valid;
    logic                          out_ready;
    logic [RATE-1:0]               out_block;
    logic                          out_last;

    modport master (
        output in_valid, in_data, in_last, in_bytes, out_ready,
        input  in_ready, out_valid, out_block, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, out_ready,
        output in_ready, out_valid, out_block, out_last
    );
endinterface

// File: rtl/keccak_pad_stream.sv
// rtl/keccak_pad_stream.sv - streaming Keccak pad10*1 padder with domain suffix and block emission
module keccak_pad_stream #(
    parameter int DIN_WIDTH  = 64,
    parameter int DOUT_WIDTH = 256,
    parameter int MODE       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    keccak_pad_stream_if.slave   bus
);
    localparam int RATE  = 1600 - 2 * DOUT_WIDTH;
    localparam int WORDS = RATE / DIN_WIDTH;
    localparam int NB    = DIN_WIDTH / 8;
    localparam int RB    = RATE / 8;
    localparam int CW    = $clog2(WORDS + 1);
    localparam int BW    = $clog2(NB) + 1;
    localparam int PW    = $clog2(RB + 1);

    // Suffix bits followed by the first pad 1, already mirrored into out_block byte order.
    localparam logic [7:0] PAD_BYTE = (MODE == 0) ? 8'h80 :
                                      (MODE == 1) ? 8'h60 : 8'hF8;
    localparam logic [RATE-1:0] PAD_BLOCK = {PAD_BYTE, {(RATE-9){1'b0}}, 1'b1};

    typedef enum logic [1:0] {FILL, EMIT, PAD} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            pending_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [RATE-1:0] block_q;

    logic [DIN_WIDTH-1:0] word_m;
    logic [PW-1:0]        pad_idx;
    logic                 pad_fits;
    logic                 accept;
    logic [RATE-1:0]      fill_block_d;

    assign accept   = (state_q == FILL) && in_ready_q && bus.in_valid;
    assign pad_idx  = PW'(cnt_q) * PW'(NB) + PW'(bus.in_bytes);
    assign pad_fits = pad_idx < PW'(RB);

    always_comb begin
        word_m = '0;
        for (int k = 0; k < NB; k++) begin
            if (!(bus.in_last && (k[BW-1:0] >= bus.in_bytes))) begin
                for (int s = 0; s < 8; s++) begin
                    word_m[DIN_WIDTH-8-8*k+s] = bus.in_data[DIN_WIDTH-1-8*k-s];
                end
            end
        end
    end

    // A tail always leaves room for the padding unless the message ends exactly on the block edge.
    always_comb begin
        fill_block_d = block_q;
        for (int w = 0; w < WORDS; w++) begin
            if (cnt_q == w[CW-1:0]) begin
                fill_block_d[RATE-1-w*DIN_WIDTH -: DIN_WIDTH] = word_m;
            end
        end
        if (bus.in_last && pad_fits) begin
            for (int b = 0; b < RB; b++) begin
                if (pad_idx == b[PW-1:0]) begin
                    fill_block_d[RATE-1-8*b -: 8] = fill_block_d[RATE-1-8*b -: 8] | PAD_BYTE;
                end
            end
            fill_block_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            block_q     <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        block_q <= fill_block_d;
                        if (bus.in_last || (cnt_q == CW'(WORDS - 1))) begin
                            state_q     <= EMIT;
                            cnt_q       <= '0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= bus.in_last && pad_fits;
                            pending_q   <= bus.in_last && !pad_fits;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        block_q     <= '0;
                        if (pending_q) begin
                            state_q   <= PAD;
                            pending_q <= 1'b0;
                        end else begin
                            state_q    <= FILL;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    block_q     <= PAD_BLOCK;
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b1;
                    state_q     <= EMIT;
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_block = block_q;
endmodule

// File: doc/keccak_pad_stream.md
Name: keccak_pad_stream

Overview:
- Streaming successor to the combinational Keccak padder.
- Accepts a message of arbitrary byte length as a sequence of DIN_WIDTH-bit words with valid/ready handshake.
- Applies byte bit-mirroring, a selectable domain suffix and pad10*1 padding.
- Emits full rate-sized blocks, plus an extra all-padding block when needed, to the downstream absorb/permutation stage over a valid/ready handshake.

Parameters:
- DIN_WIDTH, 64, input word width in bits; multiple of 8; RATE must be a multiple of DIN_WIDTH.
- DOUT_WIDTH, 256, digest width; capacity = 2*DOUT_WIDTH; RATE = 1600 - 2*DOUT_WIDTH (1088 by default, 17 words).
- MODE, 1, suffix select: 0 = Keccak (no suffix), 1 = SHA-3 (stream bits "01"), 2 = SHAKE (stream bits "1111").

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_data, in_last and in_bytes are valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DIN_WIDTH  message word. Byte k occupies in_data[DIN_WIDTH-1-8k -: 8]; byte 0 is first in the message.
- in_last  input  1  final word of the message.
- in_bytes  input  $clog2(DIN_WIDTH/8)+1  valid bytes in the final word, 0..DIN_WIDTH/8. Sampled only with in_last; ignored otherwise.
- out_valid  output  1  out_block is valid.
- out_ready  input  1  downstream accepts the block.
- out_block  output  RATE  padded block. Stream bit i maps to out_block[RATE-1-i].
- out_last  output  1  block is the final block of the message.

Behaviour:
- Reset (rst_n low at a rising edge):
  - out_valid=0, out_last=0, out_block=0, in_ready=0.
  - Word counter=0; state=FILL.
  - in_ready goes to 1 the first cycle after reset is released.
  - Reset mid-message or mid-emit discards all partial state.
- Transfers happen only when valid and ready are both high on the same edge.
- Bit order:
  - Each message byte is placed LSB-first in the stream, i.e. bit-reversed within the byte.
  - The word at counter position w occupies out_block[RATE-1-w*DIN_WIDTH -: DIN_WIDTH].
- States:
  - FILL: in_ready=1, out_valid=0. Each accepted word is stored at the counter slot and the counter increments.
    - Non-last word, counter reaches RATE/DIN_WIDTH-1: go to EMIT with out_last=0, counter wraps to 0.
    - in_last with in_bytes < DIN_WIDTH/8:
      - Bytes at index >= in_bytes are masked to 0.
      - Suffix bits are placed at the stream position immediately after the last valid byte, followed by a single 1.
      - Remaining words in the block are zero.
      - Stream bit RATE-1 (out_block[0]) is OR-ed to 1.
      - Go to EMIT with out_last=1.
    - in_last with in_bytes = DIN_WIDTH/8:
      - If the block is not full, padding starts at the next word slot and the block is emitted as above.
      - If the word fills the block exactly, go to EMIT with out_last=0 and set the pending_pad flag.
  - EMIT: out_valid=1, in_ready=0. out_block and out_last are held stable until out_ready.
    - On handshake with pending_pad=1: go to PAD. The block is cleared, padding starts at stream bit 0, and the flag is cleared.
    - Otherwise: go to FILL with the block cleared.
  - PAD: one cycle, in_ready=0. Builds the pure padding block, then goes to EMIT with out_last=1.
- Latency:
  - out_valid rises on the cycle after the handshake of the word completing a block.
  - The PAD block follows 2 cycles after the preceding handshake.
- Padding always fits in the final block, because byte granularity leaves at least 8 free bits and the suffix plus 1 needs at most 5 bits. The only overflow case is an exactly block-aligned message.
- When suffix+1 ends at stream bit RATE-1, the two 1s merge into that single bit: OR semantics, one bit set.
- in_last with in_bytes=0 is legal (empty tail); padding starts at that word's slot.
- in_valid while in_ready=0 has no effect. The upstream holds its data.

Test Plan:
- Empty message, MODE=1: in_last=1, in_bytes=0 -> one block, out_block[1087:1080]=8'h60, out_block[7:0]=8'h01, all other bits 0, out_last=1.
- Empty message, MODE=0 -> out_block[1087:1080]=8'h80, out_block[7:0]=8'h01, out_last=1.
- 135-byte message, MODE=1 (17 words, last with in_bytes=7) -> single block, out_block[7:0]=8'h61 (0x86 mirrored), out_last=1.
- 136-byte message, MODE=2 -> first block out_last=0 containing the data; second block out_block[1087:1080]=8'hF8, out_block[7:0]=8'h01, all other bits 0, out_last=1.
- Backpressure: out_ready held 0 for 5 cycles in EMIT -> out_block and out_valid stable, in_ready=0; handshake on cycle 6 -> in_ready=1 the next cycle.
- rst_n pulsed low after 9 of 17 words -> outputs 0 the next cycle; a subsequent empty message produces exactly the empty-message block.
